// File: rtl/irq_ctl.sv
// irq_ctl: memory-mapped interrupt controller merging up to eight sources into one IRQ.
// Register window at BASE: +0 PEND (W1C), +1 EN, +2 MODE (1 = edge), +3 VEC (read-only).
// Optional feature macro IRQ_CTL_NMI_EN: routes channel N-1 to a dedicated NMI output,
// forced to edge mode, independent of EN and excluded from IRQ and VEC.

module irq_ctl #(
  parameter int unsigned N    = 8,
  parameter logic [15:0] BASE = 16'hFE00
) (
  input  logic         clk,
  input  logic         RST_n,
  input  logic [15:0]  AD,
  input  logic [7:0]   DI,
  input  logic         WE,
  input  logic         RDY,
  input  logic [N-1:0] SRC,
  output logic [7:0]   DO,
  output logic         SEL,
  output logic         IRQ
`ifdef IRQ_CTL_NMI_EN
  ,
  output logic         NMI
`endif
);

  // Synchronizer and history flops
  logic [N-1:0] s1_q, s2_q, s3_q;

  // Architectural registers
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] en_q, en_d;
  logic [N-1:0] mode_q, mode_d;
  logic         irq_q, irq_d;
`ifdef IRQ_CTL_NMI_EN
  logic         nmi_q, nmi_d;
`endif

  logic [N-1:0] irq_mask;   // channels that may drive IRQ and VEC
  logic [N-1:0] edge_mode;  // effective per-channel mode
  logic [N-1:0] rise;
  logic [N-1:0] clr;
  logic [N-1:0] act;        // pending and enabled, eligible for IRQ
  logic         wr;
  logic [7:0]   pend_rd, en_rd, mode_rd, vec;

  assign SEL = (AD[15:2] == BASE[15:2]);
  assign wr  = SEL & WE & RDY;

  // Channel routing: the NMI channel is masked out of IRQ/VEC and pinned to edge mode
  always_comb begin
    irq_mask = '1;
`ifdef IRQ_CTL_NMI_EN
    irq_mask[N-1] = 1'b0;
`endif
    edge_mode = mode_q | ~irq_mask;
  end

  // Two-flop synchronizer plus history flop for edge detection
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= SRC;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Next-state for registers: bus writes, edge capture, level follow, W1C (set wins)
  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    clr    = '0;
    if (wr) begin
      unique case (AD[1:0])
        2'd0:    clr    = DI[N-1:0];
        2'd1:    en_d   = DI[N-1:0];
        2'd2:    mode_d = DI[N-1:0];
        default: ;
      endcase
    end
    rise = s2_q & ~s3_q;
    for (int i = 0; i < int'(N); i++) begin
      pend_d[i] = edge_mode[i] ? (rise[i] | (pend_q[i] & ~clr[i])) : s2_q[i];
    end
    act   = pend_q & en_q & irq_mask;
    irq_d = |act;
`ifdef IRQ_CTL_NMI_EN
    nmi_d = pend_q[N-1];
`endif
  end

  // Register state
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      pend_q <= '0;
      en_q   <= '0;
      mode_q <= '1;
      irq_q  <= 1'b0;
`ifdef IRQ_CTL_NMI_EN
      nmi_q  <= 1'b0;
`endif
    end else begin
      pend_q <= pend_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      irq_q  <= irq_d;
`ifdef IRQ_CTL_NMI_EN
      nmi_q  <= nmi_d;
`endif
    end
  end

  // Read path: zero-extend unused channels, priority-encode VEC (channel 0 wins)
  always_comb begin
    pend_rd = '0;
    en_rd   = '0;
    mode_rd = '0;
    pend_rd[N-1:0] = pend_q;
    en_rd[N-1:0]   = en_q;
    mode_rd[N-1:0] = mode_q;
    vec = 8'hFF;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (act[i]) vec = 8'(i);
    end
    unique case (AD[1:0])
      2'd0:    DO = pend_rd;
      2'd1:    DO = en_rd;
      2'd2:    DO = mode_rd;
      default: DO = vec;
    endcase
  end

  assign IRQ = irq_q;
`ifdef IRQ_CTL_NMI_EN
  assign NMI = nmi_q;
`endif

endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: directed test-plan sequences then randomized traffic, all checked by a
// scoreboard fed from a behavioural model that works on a history of sampled source values.

module tb_irq_ctl;

  localparam int unsigned N    = 8;
  localparam logic [15:0] BASE = 16'hFE00;
`ifdef IRQ_CTL_NMI_EN
  localparam bit HasNmi = 1'b1;
`else
  localparam bit HasNmi = 1'b0;
`endif
  localparam logic [7:0] MASK = HasNmi ? 8'h7F : 8'hFF;

  logic        clk = 1'b0;
  logic        RST_n = 1'b0;
  logic [15:0] AD = 16'h0000;
  logic [7:0]  DI = 8'h00;
  logic        WE = 1'b0;
  logic        RDY = 1'b1;
  logic [7:0]  SRC = 8'h00;
  logic [7:0]  DO;
  logic        SEL;
  logic        IRQ;
`ifdef IRQ_CTL_NMI_EN
  logic        NMI;
`endif

  irq_ctl #(.N(N), .BASE(BASE)) dut (
    .clk  (clk),
    .RST_n(RST_n),
    .AD   (AD),
    .DI   (DI),
    .WE   (WE),
    .RDY  (RDY),
    .SRC  (SRC),
    .DO   (DO),
    .SEL  (SEL),
    .IRQ  (IRQ)
`ifdef IRQ_CTL_NMI_EN
    ,
    .NMI  (NMI)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         is_const;
    logic [7:0] do_v;
    logic       sel_v;
    logic       irq_v;
    logic       nmi_v;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_pend, m_en, m_mode;
  logic       m_irq, m_nmi;
  logic [7:0] samp[$];  // samp[0] = most recent SRC sample
  logic [7:0] src_now = 8'h00;

  function automatic logic in_win(input logic [15:0] a);
    return a[15:2] == BASE[15:2];
  endfunction

  function automatic void model_reset();
    m_pend = 8'h00;
    m_en   = 8'h00;
    m_mode = 8'hFF;
    m_irq  = 1'b0;
    m_nmi  = 1'b0;
    samp.delete();
    for (int i = 0; i < 3; i++) samp.push_back(8'h00);
  endfunction

  function automatic logic [7:0] m_vec();
    for (int i = 0; i < 8; i++) begin
      if (m_pend[i] && m_en[i] && MASK[i]) return 8'(i);
    end
    return 8'hFF;
  endfunction

  function automatic logic [7:0] m_do(input logic [1:0] off);
    case (off)
      2'd0:    return m_pend;
      2'd1:    return m_en;
      2'd2:    return m_mode;
      default: return m_vec();
    endcase
  endfunction

  // One clock edge of the spec rules, using the inputs present at that edge
  function automatic void model_step();
    logic [7:0] s2, s3, np;
    logic       w, new_irq, new_nmi, is_edge;
    s2      = samp[1];
    s3      = samp[2];
    w       = in_win(AD) && WE && RDY;
    new_irq = |(m_pend & m_en & MASK);
    new_nmi = HasNmi ? m_pend[7] : 1'b0;
    for (int i = 0; i < 8; i++) begin
      is_edge = m_mode[i] || (HasNmi && i == 7);
      if (!is_edge) np[i] = s2[i];
      else if (s2[i] && !s3[i]) np[i] = 1'b1;
      else if (w && AD[1:0] == 2'd0 && DI[i]) np[i] = 1'b0;
      else np[i] = m_pend[i];
    end
    if (w && AD[1:0] == 2'd1) m_en = DI;
    if (w && AD[1:0] == 2'd2) m_mode = DI;
    m_pend = np;
    m_irq  = new_irq;
    m_nmi  = new_nmi;
    samp.push_front(SRC);
    void'(samp.pop_back());
  endfunction

  task automatic cycle(input logic [15:0] ad, input logic [7:0] di, input logic we,
                       input logic rdy, input logic [7:0] src, input logic rstn,
                       input string nm);
    exp_t e;
    @(posedge clk);
    if (RST_n) model_step();
    #1;
    AD = ad; DI = di; WE = we; RDY = rdy; SRC = src; RST_n = rstn;
    if (!rstn) model_reset();
    e.name = nm; e.is_const = 1'b0; e.do_v = m_do(ad[1:0]);
    e.sel_v = in_win(ad); e.irq_v = m_irq; e.nmi_v = m_nmi;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    cycle(BASE | 16'(off), d, 1'b1, 1'b1, src_now, 1'b1, "wr");
  endtask

  task automatic rd(input logic [1:0] off);
    cycle(BASE | 16'(off), 8'h00, 1'b0, 1'b1, src_now, 1'b1, "rd");
  endtask

  task automatic chk_do(input string nm, input logic [7:0] v);
    exp_t e;
    e.name = nm; e.is_const = 1'b1; e.do_v = v;
    e.sel_v = 1'b0; e.irq_v = 1'b0; e.nmi_v = 1'b0;
    sb.push_back(e);
  endtask

  function automatic void cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: outputs are settled mid-cycle; pop everything queued this cycle
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_const) begin
        cmp({e.name, ".DO"}, DO, e.do_v);
      end else begin
        cmp({e.name, ".SEL"}, {7'b0, SEL}, {7'b0, e.sel_v});
        cmp({e.name, ".IRQ"}, {7'b0, IRQ}, {7'b0, e.irq_v});
`ifdef IRQ_CTL_NMI_EN
        cmp({e.name, ".NMI"}, {7'b0, NMI}, {7'b0, e.nmi_v});
`endif
        if (e.sel_v) cmp({e.name, ".DO"}, DO, e.do_v);
      end
    end
  end

  initial begin
    logic [15:0] ad;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(BASE, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, "reset");

    // Reset values and read-back
    rd(2'd0); chk_do("rst_pend", 8'h00);
    rd(2'd1); chk_do("rst_en", 8'h00);
    rd(2'd2); chk_do("rst_mode", 8'hFF);
    rd(2'd3); chk_do("rst_vec", 8'hFF);
    wr(2'd1, 8'h05);
    rd(2'd1); chk_do("en_readback", 8'h05);

    // Edge path on channel 0
    wr(2'd1, 8'h01);
    src_now = 8'h01; rd(2'd3);
    src_now = 8'h00;
    for (int i = 0; i < 5; i++) rd(2'd3);
    chk_do("edge_vec", 8'h00);
    wr(2'd0, 8'h01);
    rd(2'd3); rd(2'd3);
    chk_do("edge_vec_clr", 8'hFF);

    // Priority between channels 2 and 5
    wr(2'd1, 8'hFF);
    src_now = 8'h24;
    for (int i = 0; i < 6; i++) rd(2'd3);
    chk_do("prio_vec", 8'h02);
    wr(2'd0, 8'h04);
    rd(2'd3); chk_do("prio_vec_next", 8'h05);
    src_now = 8'h00;
    wr(2'd0, 8'hFF);

    // Level mode on channel 3
    wr(2'd2, 8'h00);
    wr(2'd1, 8'h08);
    src_now = 8'h08;
    for (int i = 0; i < 5; i++) rd(2'd0);
    wr(2'd0, 8'h08);
    rd(2'd0); chk_do("level_w1c", 8'h08);
    src_now = 8'h00;
    for (int i = 0; i < 4; i++) rd(2'd0);
    chk_do("level_drop", 8'h00);

    // Set-wins collision on channel 1, then writes with RDY=0
    wr(2'd2, 8'hFF);
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'h02);
    src_now = 8'h02;
    rd(2'd0); rd(2'd0);
    wr(2'd0, 8'h02);
    rd(2'd0); chk_do("collision", 8'h02);
    cycle(BASE, 8'h02, 1'b1, 1'b0, src_now, 1'b1, "w1c_stall");
    rd(2'd0); chk_do("stall_pend", 8'h02);
    cycle(BASE | 16'h1, 8'h00, 1'b1, 1'b0, src_now, 1'b1, "en_stall");
    rd(2'd1); chk_do("stall_en", 8'h02);
    src_now = 8'h00;
    wr(2'd0, 8'hFF);

    // Channel 7 with EN=0: NMI when built with the option, nothing on IRQ/VEC either way
    wr(2'd1, 8'h00);
    src_now = 8'h80; rd(2'd3);
    src_now = 8'h00;
    for (int i = 0; i < 5; i++) rd(2'd3);
    chk_do("ch7_vec", 8'hFF);
    wr(2'd0, 8'h80);
    rd(2'd3); rd(2'd3);

    // Randomized traffic with one asynchronous reset mid-run
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 9) < 8) ad = BASE | 16'($urandom_range(0, 3));
      else ad = 16'($urandom);
      src_now = src_now ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      cycle(ad, 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
            src_now, it != 1500, "rand");
    end
    rd(2'd3);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
